conv12_ctrl: RTL and testbench

//  Sequencer for the 12x12 / 3x3 convolution array (10x10 mac_new grid, 2-bit pixels).
//  - Streams a 12x12 image in row-by-row into an image buffer.
//  - Holds the 3x3 filter register.
//  - Waits out the MAC pipeline, then streams the 10x10 result out row-by-row.
//  - Drives the array's in/filter buses and samples its out bus.

---
 rtl/conv12_ctrl.sv | 146 ++++++++++++++
 tb/tb_conv12_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/conv12_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : conv12_ctrl
//  Description : Sequencer for the 12x12 / 3x3 convolution array. Buffers an
//                incoming image row by row, holds the filter register, waits
//                out the MAC pipeline, captures the result and streams it out
//                row by row with valid/ready handshaking.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv12_ctrl #(
    parameter int IN_DIM  = 12,
    parameter int K       = 3,
    parameter int PW      = 2,
    parameter int MAC_LAT = 2
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        start,
    output logic                                        busy,
    output logic                                        done,
    input  logic                                        filt_we,
    input  logic [K*K*PW-1:0]                           filt_data,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic [IN_DIM*PW-1:0]                        in_row,
    output logic [IN_DIM*IN_DIM*PW-1:0]                 conv_in,
    output logic [K*K*PW-1:0]                           conv_filter,
    input  logic [(IN_DIM-K+1)*(IN_DIM-K+1)*PW-1:0]     conv_out,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [(IN_DIM-K+1)*PW-1:0]                  out_row,
    output logic                                        out_last
);

    localparam int c_OUT_DIM = IN_DIM - K + 1;
    localparam int c_IN_RW   = IN_DIM * PW;
    localparam int c_OUT_RW  = c_OUT_DIM * PW;
    localparam int c_ROW_W   = $clog2(IN_DIM);
    localparam int c_K_W     = $clog2(c_OUT_DIM);
    localparam int c_LAT_W   = (MAC_LAT > 0) ? $clog2(MAC_LAT + 1) : 1;

    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(IN_DIM - 1);
    localparam logic [c_K_W-1:0]   c_K_LAST   = c_K_W'(c_OUT_DIM - 1);
    localparam logic [c_LAT_W-1:0] c_LAT_LAST = c_LAT_W'(MAC_LAT);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_LOAD    = 2'd1;
    localparam logic [1:0] c_COMPUTE = 2'd2;
    localparam logic [1:0] c_DRAIN   = 2'd3;

    logic [1:0]          r_state;
    logic [1:0]          w_next;
    logic [c_IN_RW-1:0]  r_img [IN_DIM];
    logic [c_OUT_RW-1:0] r_res [c_OUT_DIM];
    logic [K*K*PW-1:0]   r_filt;
    logic [c_ROW_W-1:0]  r_row;
    logic [c_K_W-1:0]    r_k;
    logic [c_LAT_W-1:0]  r_lat;
    logic                r_done;
    logic                w_in_fire;
    logic                w_out_fire;

    // State register; reset abandons any partial frame.
    always_ff @(posedge clk) begin
        if (rst) r_state <= c_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic: start only honoured in IDLE, so no queueing elsewhere.
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:    if (start) w_next = c_LOAD;
            c_LOAD:    if (in_valid && (r_row == c_ROW_LAST)) w_next = c_COMPUTE;
            c_COMPUTE: if (r_lat == c_LAT_LAST) w_next = c_DRAIN;
            c_DRAIN:   if (out_ready && (r_k == c_K_LAST)) w_next = c_IDLE;
            default:   w_next = c_IDLE;
        endcase
    end

    // Output decode; out_row is forced to zero outside DRAIN.
    always_comb begin
        busy       = (r_state != c_IDLE);
        in_ready   = (r_state == c_LOAD);
        out_valid  = (r_state == c_DRAIN);
        out_last   = (r_state == c_DRAIN) && (r_k == c_K_LAST);
        out_row    = '0;
        if (r_state == c_DRAIN) out_row = r_res[r_k];
        w_in_fire  = in_valid && (r_state == c_LOAD);
        w_out_fire = out_ready && (r_state == c_DRAIN);
    end

    // Filter register: writable only while idle, frozen for the whole frame.
    always_ff @(posedge clk) begin
        if (rst)                               r_filt <= '0;
        else if ((r_state == c_IDLE) && filt_we) r_filt <= filt_data;
    end

    // Image buffer and load row counter; each frame overwrites every row.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_row <= '0;
            for (int i = 0; i < IN_DIM; i++) r_img[i] <= '0;
        end else if (w_in_fire) begin
            r_img[r_row] <= in_row;
            r_row        <= (r_row == c_ROW_LAST) ? '0 : r_row + c_ROW_W'(1);
        end
    end

    // MAC latency counter; result captured on the final COMPUTE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lat <= '0;
            for (int i = 0; i < c_OUT_DIM; i++) r_res[i] <= '0;
        end else if (r_state == c_COMPUTE) begin
            if (r_lat == c_LAT_LAST) begin
                r_lat <= '0;
                for (int i = 0; i < c_OUT_DIM; i++) r_res[i] <= conv_out[i*c_OUT_RW +: c_OUT_RW];
            end else begin
                r_lat <= r_lat + c_LAT_W'(1);
            end
        end
    end

    // Drain row index and one-cycle done pulse after the last row is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_k    <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_out_fire && (r_k == c_K_LAST);
            if (w_out_fire) r_k <= (r_k == c_K_LAST) ? '0 : r_k + c_K_W'(1);
        end
    end

    // The array sees the image buffer row-major, row r at [r*row_width +: row_width].
    for (genvar g = 0; g < IN_DIM; g++) begin : g_conv_in
        assign conv_in[g*c_IN_RW +: c_IN_RW] = r_img[g];
    end

    assign conv_filter = r_filt;
    assign done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_conv12_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_conv12_ctrl
//  Description : Self-checking bench for conv12_ctrl with a behavioural MAC
//                array stub and a row scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conv12_ctrl;

    logic         clk = 1'b0;
    logic         rst, start, busy, done, filt_we;
    logic         in_valid, in_ready, out_valid, out_ready, out_last;
    logic [17:0]  filt_data, conv_filter;
    logic [23:0]  in_row;
    logic [287:0] conv_in;
    logic [199:0] conv_out, r_s1, r_s2;
    logic [19:0]  out_row;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int cur_vec  = -1;
    logic [19:0] sb[$];

    typedef struct {
        logic [17:0] filt;
        int          pat;
        bit          with_start;
        bit          toggle;
        bit          filt_in_load;
        int          stall_k;
        int          stall_len;
        bit          poke;
        int          abort_beat;
        int          abort_k;
        bit          use_exp;
        logic [19:0] exp_row0;
    } vec_t;

    vec_t vecs[9];

    always #5 clk = ~clk;

    conv12_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .filt_we(filt_we), .filt_data(filt_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
        .conv_in(conv_in), .conv_filter(conv_filter), .conv_out(conv_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
        .out_last(out_last)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // 3x3 MAC reference: each result pixel is the tap-weighted sum, modulo 4
    function automatic logic [199:0] mac(input logic [287:0] img, input logic [17:0] f);
        logic [199:0] res;
        int acc;
        res = '0;
        for (int r = 0; r < 10; r++)
            for (int c = 0; c < 10; c++) begin
                acc = 0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        acc += int'(img[24*(r+i) + 2*(c+j) +: 2]) * int'(f[2*(3*i+j) +: 2]);
                res[20*r + 2*c +: 2] = 2'(acc);
            end
        return res;
    endfunction

    // Array stub: MAC_LAT = 2 register stages
    always @(posedge clk) begin
        r_s1 <= mac(conv_in, conv_filter);
        r_s2 <= r_s1;
    end
    assign conv_out = r_s2;

    task automatic chk(input string name, input logic [287:0] act, input logic [287:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL v%0d %s: got %0h expected %0h", cur_vec, name, act, exp);
    endtask

    task automatic fail_timeout(input string name);
        n_checks++;
        $display("FAIL v%0d %s: timed out, got no event expected event", cur_vec, name);
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; filt_we = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_flags", {busy, done, in_ready, out_valid, out_last}, '0);
        chk("rst_conv_in", conv_in, '0);
        chk("rst_filter", conv_filter, '0);
        chk("rst_out_row", out_row, '0);
        @(posedge clk); #1;
    endtask

    task automatic run_frame(input vec_t v);
        logic [23:0]  img [12];
        logic [287:0] imgvec;
        logic [199:0] exp;
        logic [19:0]  front;
        int beat, g, t_last, k, stall_left;
        bit hs, phase;

        for (int i = 0; i < 12; i++) begin
            case (v.pat)
                0: img[i] = {12{2'b01}};
                1: for (int c = 0; c < 12; c++) img[i][2*c +: 2] = 2'(i);
                default: img[i] = 24'($urandom);
            endcase
            imgvec[24*i +: 24] = img[i];
        end
        exp = mac(imgvec, v.filt);

        if (!v.with_start) begin
            filt_we = 1'b1; filt_data = v.filt;
            @(negedge clk); chk("idle_busy", busy, 1'b0);
            @(posedge clk); #1 filt_we = 1'b0;
        end
        start = 1'b1;
        if (v.with_start) begin filt_we = 1'b1; filt_data = v.filt; end
        @(negedge clk);
        chk("idle_state", {busy, in_ready, out_valid, done}, '0);
        @(posedge clk); #1 start = 1'b0; filt_we = 1'b0;

        beat = 0; g = 0; phase = 1'b1; t_last = 0;
        while (beat < 12) begin
            if (beat == v.abort_beat) begin do_reset(); return; end
            in_row   = img[beat];
            in_valid = v.toggle ? phase : 1'b1;
            phase    = !phase;
            if (v.filt_in_load && beat == 3) begin filt_we = 1'b1; filt_data = '0; end
            @(negedge clk);
            hs = in_valid && in_ready;
            if (hs) t_last = cyc;
            @(posedge clk); #1 filt_we = 1'b0;
            if (hs) beat++;
            if (++g > 100) begin fail_timeout("load"); break; end
        end
        in_valid = 1'b0;
        for (int r = 0; r < 10; r++) sb.push_back(exp[20*r +: 20]);

        if (v.poke) start = 1'b1;
        @(negedge clk);
        chk("compute_conv_in", conv_in, imgvec);
        chk("compute_filter", conv_filter, v.filt);
        chk("compute_flags", {busy, in_ready, out_valid}, 3'b100);
        @(posedge clk); #1 start = 1'b0;

        g = 0;
        forever begin
            @(negedge clk);
            if (out_valid || g > 20) break;
            g++;
            @(posedge clk); #1;
        end
        chk("latency", cyc - t_last, 4);
        if (!out_valid) begin sb.delete(); do_reset(); return; end

        k = 0; stall_left = v.stall_len; g = 0;
        while (k < 10) begin
            if (k == v.abort_k) begin sb.delete(); do_reset(); return; end
            front = (sb.size() > 0) ? sb[0] : 'x;
            chk("drain_valid_ready", {out_valid, in_ready}, 2'b10);
            chk("drain_row", out_row, front);
            chk("drain_last", out_last, (k == 9));
            if (out_ready) begin
                if (k == 0 && v.use_exp) chk("row0_const", out_row, v.exp_row0);
                if (sb.size() > 0) void'(sb.pop_front());
                k++;
            end else begin
                stall_left--;
            end
            if (++g > 100) begin fail_timeout("drain"); break; end
            @(posedge clk); #1;
            out_ready = !(k == v.stall_k && stall_left > 0);
            start     = v.poke && (k == 2);
            if (k < 10) @(negedge clk);
        end
        start = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("done_pulse", {done, busy, out_valid}, 3'b100);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; filt_we = 1'b0; filt_data = '0;
        in_valid = 1'b0; in_row = '0; out_ready = 1'b1;

        //          filt       pat ws  tog fil stk sln pk  abb abk ue  row0
        vecs[0] = '{18'h15555, 0, 1'b0, 1'b0, 1'b0, -1, 0, 1'b0, -1, -1, 1'b1, 20'h55555};
        vecs[1] = '{18'h15555, 1, 1'b0, 1'b1, 1'b0, -1, 0, 1'b0, -1, -1, 1'b1, 20'h55555};
        vecs[2] = '{18'h2AAAA, 2, 1'b0, 1'b0, 1'b0,  3, 5, 1'b0, -1, -1, 1'b0, 20'h0};
        vecs[3] = '{18'h3FFFF, 1, 1'b1, 1'b0, 1'b1, -1, 0, 1'b0, -1, -1, 1'b1, 20'hFFFFF};
        vecs[4] = '{18'h15555, 0, 1'b0, 1'b0, 1'b0, -1, 0, 1'b0,  6, -1, 1'b0, 20'h0};
        vecs[5] = '{18'h1B1B1, 2, 1'b0, 1'b0, 1'b0, -1, 0, 1'b0, -1,  5, 1'b0, 20'h0};
        vecs[6] = '{18'h15555, 2, 1'b0, 1'b0, 1'b0, -1, 0, 1'b0, -1, -1, 1'b0, 20'h0};
        vecs[7] = '{18'h2D2D2, 2, 1'b1, 1'b0, 1'b0, -1, 0, 1'b1, -1, -1, 1'b0, 20'h0};
        vecs[8] = '{18'h3FFFF, 1, 1'b1, 1'b0, 1'b0, -1, 0, 1'b0, -1, -1, 1'b1, 20'hFFFFF};

        do_reset();
        for (int i = 0; i < 9; i++) begin
            cur_vec = i;
            run_frame(vecs[i]);
        end
        @(negedge clk);
        chk("final_idle", {busy, done, out_valid}, '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
